shreg_univ: RTL

- Parametrised universal shift register; successor to the single-bit negative-edge D flip-flop.
- Supports WIDTH bits, a selectable active clock edge, and four modes: hold, shift right, shift left, parallel load.
- Tracks shifts since the last load, so it can act as a serialiser/deserialiser front end in the sequential-logic experiments.

---
 rtl/shreg_univ.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/shreg_univ.sv
// ---------------------------------------------------------------------------
// shreg_univ
//
// Purpose:
//   Parametrised universal shift register with a selectable active clock
//   edge. Supports four modes: hold, shift right, shift left and parallel
//   load. It also counts the shifts made since the last load or reset.
//   The count saturates at WIDTH, so 'done' marks the point where a full
//   word has been serialised or deserialised.
//
// Optional feature:
//   Define SHREG_ROTATE_EN to turn the two shift modes into rotates.
//   In that build sin_msb and sin_lsb are ignored, and after WIDTH
//   rotations q is back at its loaded value.
//
// Parameters:
//   WIDTH    - register width in bits (>= 2)
//   NEG_EDGE - 1: state updates on the falling edge of clk; 0: rising edge
//   CW       - shift counter width (derived from WIDTH; do not override)
//
// Ports:
//   clk      in   clock; the active edge is selected by NEG_EDGE
//   reset    in   synchronous, active-high; sampled on the active edge
//   mode     in   00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_msb  in   serial bit that enters the MSB on a shift right
//   sin_lsb  in   serial bit that enters the LSB on a shift left
//   d        in   parallel load data
//   q        out  register contents
//   sout_lsb out  q[0]
//   sout_msb out  q[WIDTH-1]
//   cnt      out  shifts since the last load/reset, saturating at WIDTH
//   done     out  high when cnt == WIDTH
// ---------------------------------------------------------------------------
module shreg_univ #(
    parameter int WIDTH    = 4,
    parameter bit NEG_EDGE = 1'b1,
    parameter int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    // Bits that enter the vacated end on a shift. In the rotate build they
    // come from the opposite end of the register.
    logic             fill_msb;
    logic             fill_lsb;

`ifdef SHREG_ROTATE_EN
    assign fill_msb = q_q[0];
    assign fill_lsb = q_q[WIDTH-1];
`else
    assign fill_msb = sin_msb;
    assign fill_lsb = sin_lsb;
`endif

    // Saturating shift count. Both directions feed the same counter.
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        if (c < CNT_MAX) begin
            return c + CW'(1);
        end
        return c;
    endfunction

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        case (mode)
            MODE_HOLD: begin
                q_d   = q_q;
                cnt_d = cnt_q;
            end
            MODE_SHR: begin
                q_d   = {fill_msb, q_q[WIDTH-1:1]};
                cnt_d = cnt_inc(cnt_q);
            end
            MODE_SHL: begin
                q_d   = {q_q[WIDTH-2:0], fill_lsb};
                cnt_d = cnt_inc(cnt_q);
            end
            MODE_LOAD: begin
                q_d   = d;
                cnt_d = '0;
            end
            default: begin
                q_d   = q_q;
                cnt_d = cnt_q;
            end
        endcase
    end

    // Only one of these register processes is elaborated, so the state is
    // clocked on exactly one edge of clk.
    generate
        if (NEG_EDGE) begin : g_negedge
            always_ff @(negedge clk) begin
                if (reset) begin
                    q_q   <= '0;
                    cnt_q <= '0;
                end else begin
                    q_q   <= q_d;
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_posedge
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_q   <= '0;
                    cnt_q <= '0;
                end else begin
                    q_q   <= q_d;
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign q        = q_q;
    assign sout_lsb = q_q[0];
    assign sout_msb = q_q[WIDTH-1];
    assign cnt      = cnt_q;
    assign done     = (cnt_q == CNT_MAX);

endmodule
